twos_comp_decoder: RTL



---
 rtl/twos_comp_decoder_if.sv | 32 +++
 rtl/twos_comp_decoder.sv | 116 +++++++++++
 2 files changed

// File: rtl/twos_comp_decoder_if.sv
// ============================================================================
// twos_comp_decoder_if
// Valid/ready handshake bundle for the two's-complement to sign-magnitude
// decoder: one word in, one sign/magnitude result out.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface twos_comp_decoder_if #(
  parameter int WIDTH = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic             out_valid;
  logic             out_ready;
  logic             sign;
  logic [WIDTH-1:0] mag;
  logic             is_min;

  modport master (
    output in_valid, A, out_ready,
    input  in_ready, out_valid, sign, mag, is_min
  );

  modport slave (
    input  in_valid, A, out_ready,
    output in_ready, out_valid, sign, mag, is_min
  );
endinterface

`default_nettype wire

// File: rtl/twos_comp_decoder.sv
// ============================================================================
// twos_comp_decoder
// Bit-serial, LSB-first conversion of a two's-complement word into sign plus
// unsigned magnitude, with constant WIDTH-cycle latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module twos_comp_decoder #(
  parameter int WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  twos_comp_decoder_if.slave   bus
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_WORD = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sign_q, sign_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             is_min_q, is_min_d;
  logic             bit_in;
  logic             bit_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      mag_q    <= '0;
      is_min_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      mag_q    <= mag_d;
      is_min_q <= is_min_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    mag_d    = mag_q;
    is_min_d = is_min_q;
    bit_in   = 1'b0;
    bit_out  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d  = SHIFT;
          sh_d     = bus.A;
          sign_d   = bus.A[WIDTH-1];
          cnt_d    = '0;
          seen_d   = 1'b0;
          mag_d    = '0;
          is_min_d = 1'b0;
        end
      end

      SHIFT: begin
        // Negation: copy bits up to and including the first 1, invert the rest.
        bit_in         = sh_q[cnt_q];
        bit_out        = (sign_q && seen_q) ? ~bit_in : bit_in;
        mag_d[cnt_q]   = bit_out;
        seen_d         = seen_q | bit_in;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          is_min_d = sign_q && (sh_q == MIN_WORD);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sign      = sign_q;
  assign bus.mag       = mag_q;
  assign bus.is_min    = is_min_q;

endmodule

`default_nettype wire
